// File: rtl/uart_param_transceiver.sv
// Full-duplex UART with configurable word width, runtime parity/stop selection,
// first-word-fall-through RX FIFO with per-word error flags, and internal loopback.
module uart_param_transceiver #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic [1:0]           parity_sel,
  input  logic                 stop2,
  input  logic                 loopback,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 Tx_BUSY,
  output logic                 TxD,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  input  logic                 Rx_RD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_VALID,
  output logic                 Rx_OVERRUN
);

  localparam int unsigned DIV_MAX = CLK_HZ / (16 * 300);
  localparam int unsigned DW      = $clog2(DIV_MAX + 1);
  localparam int unsigned IW      = $clog2(DATA_BITS);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EW      = DATA_BITS + 2;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  function automatic logic [DW-1:0] baud_div(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return DW'(CLK_HZ / (16 * baud));
  endfunction

  // ---------------- baud divider ----------------
  logic [DW-1:0]   div;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      baud_q;
  logic            tick_raw;
  logic            tick16;
  logic [DW+3:0]   bit_last;

  assign div      = baud_div(baud_select);
  assign tick_raw = (div_cnt == div - 1'b1);
  assign tick16   = tick_raw && (baud_select == baud_q);
  assign bit_last = {div, 4'b0000} - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      baud_q  <= '0;
    end else begin
      baud_q <= baud_select;
      if ((baud_select != baud_q) || tick_raw) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  tx_state_t          tx_state;
  logic [DW+3:0]      tx_cnt;
  logic [IW-1:0]      tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic               tx_par_en;
  logic               tx_par_bit;
  logic               tx_stop2;
  logic               tx_line;

  // Each bit is timed by its own clock counter so bit lengths are exact from acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_line    <= 1'b1;
      Tx_BUSY    <= 1'b0;
    end else if (!Tx_EN) begin
      tx_state <= TX_IDLE;
      tx_line  <= 1'b1;
      Tx_BUSY  <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (Tx_WR) begin
        tx_state   <= TX_START;
        tx_line    <= 1'b0;
        Tx_BUSY    <= 1'b1;
        tx_cnt     <= '0;
        tx_shift   <= Tx_DATA;
        tx_par_en  <= (parity_sel != 2'b00);
        tx_par_bit <= (parity_sel == 2'b10) ? ~^Tx_DATA : ^Tx_DATA;
        tx_stop2   <= stop2;
      end
    end else if (tx_cnt != bit_last) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_idx   <= '0;
          tx_line  <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
        end
        TX_DATA: begin
          if (tx_idx == IDX_LAST) begin
            tx_state <= tx_par_en ? TX_PARITY : TX_STOP1;
            tx_line  <= tx_par_en ? tx_par_bit : 1'b1;
          end else begin
            tx_idx   <= tx_idx + 1'b1;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end
        TX_PARITY: begin
          tx_state <= TX_STOP1;
          tx_line  <= 1'b1;
        end
        TX_STOP1: begin
          if (tx_stop2) begin
            tx_state <= TX_STOP2;
          end else begin
            tx_state <= TX_IDLE;
            Tx_BUSY  <= 1'b0;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
          Tx_BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign TxD = loopback ? 1'b1 : tx_line;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  rx_state_t            rx_state;
  logic                 sync1;
  logic                 sync2;
  logic                 rx_in;
  logic [3:0]           rx_tick;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 sample;
  logic                 exp_par;
  logic                 push;
  logic [EW-1:0]        push_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= loopback ? tx_line : RxD;
      sync2 <= sync1;
    end
  end

  assign rx_in     = sync2;
  assign sample    = tick16 && (rx_tick == 4'd15);
  assign exp_par   = (parity_sel == 2'b10) ? ~^rx_shift : ^rx_shift;
  assign push      = Rx_EN && (rx_state == RX_STOP) && sample;
  assign push_word = {~rx_in, rx_perr, rx_shift};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else if (!Rx_EN) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_in) begin
            rx_state <= RX_START;
            rx_tick  <= '0;
          end
        end
        RX_START: begin
          if (tick16) begin
            if (rx_tick == 4'd7) begin
              rx_tick <= '0;
              if (rx_in) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_state <= RX_DATA;
                rx_idx   <= '0;
                rx_perr  <= 1'b0;
              end
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick16) rx_tick <= rx_tick + 1'b1;
          if (sample) begin
            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == IDX_LAST)
              rx_state <= (parity_sel != 2'b00) ? RX_PARITY : RX_STOP;
            else
              rx_idx <= rx_idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (tick16) rx_tick <= rx_tick + 1'b1;
          if (sample) begin
            rx_perr  <= rx_in ^ exp_par;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick16) rx_tick <= rx_tick + 1'b1;
          if (sample) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = Rx_RD && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Rx_OVERRUN <= 1'b0;
    end else if (!Rx_EN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Rx_OVERRUN <= 1'b0;
    end else begin
      if (push_ok)                wr_ptr     <= wr_ptr + 1'b1;
      if (pop)                    rd_ptr     <= rd_ptr + 1'b1;
      if (push && full && !pop)   Rx_OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign Rx_VALID  = !empty;
  assign Rx_DATA   = Rx_VALID ? head[DATA_BITS-1:0] : '0;
  assign Rx_PERROR = Rx_VALID && head[DATA_BITS];
  assign Rx_FERROR = Rx_VALID && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_param_transceiver.sv
// Randomised self-checking bench: frame timing and received words are predicted
// from baud/frame arithmetic and a queue model of the receive FIFO.
module tb_uart_param_transceiver;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned EW         = DATA_BITS + 2;

  logic                 clk;
  logic                 reset;
  logic [2:0]           baud_select;
  logic [1:0]           parity_sel;
  logic                 stop2;
  logic                 loopback;
  logic                 Tx_EN;
  logic                 Tx_WR;
  logic [DATA_BITS-1:0] Tx_DATA;
  logic                 Tx_BUSY;
  logic                 TxD;
  logic                 Rx_EN;
  logic                 RxD;
  logic                 Rx_RD;
  logic [DATA_BITS-1:0] Rx_DATA;
  logic                 Rx_PERROR;
  logic                 Rx_FERROR;
  logic                 Rx_VALID;
  logic                 Rx_OVERRUN;

  uart_param_transceiver #(
    .CLK_HZ    (CLK_HZ),
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .parity_sel (parity_sel),
    .stop2      (stop2),
    .loopback   (loopback),
    .Tx_EN      (Tx_EN),
    .Tx_WR      (Tx_WR),
    .Tx_DATA    (Tx_DATA),
    .Tx_BUSY    (Tx_BUSY),
    .TxD        (TxD),
    .Rx_EN      (Rx_EN),
    .RxD        (RxD),
    .Rx_RD      (Rx_RD),
    .Rx_DATA    (Rx_DATA),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_VALID   (Rx_VALID),
    .Rx_OVERRUN (Rx_OVERRUN)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic          exp_ovr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned div_of(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return CLK_HZ / (16 * baud);
  endfunction

  function automatic int unsigned frame_clocks(input logic [2:0] sel, input logic [1:0] par, input logic s2);
    int unsigned bits;
    bits = 1 + DATA_BITS + ((par != 2'b00) ? 1 : 0) + (s2 ? 2 : 1);
    return bits * 16 * div_of(sel);
  endfunction

  // Parity bit that makes the total count of ones even (or odd for selection 10).
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] sel);
    return (sel == 2'b10) ? ~^d : ^d;
  endfunction

  task automatic model_push(input logic ferr, input logic perr, input logic [DATA_BITS-1:0] d);
    if (exp_q.size() == FIFO_DEPTH) exp_ovr = 1'b1;
    else                            exp_q.push_back({ferr, perr, d});
  endtask

  task automatic check_head(input bit do_pop);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("rx_valid_empty", 32'(Rx_VALID), 0);
      return;
    end
    e = exp_q[0];
    check_eq("rx_valid", 32'(Rx_VALID), 1);
    check_eq("rx_data", 32'(Rx_DATA), 32'(e[DATA_BITS-1:0]));
    check_eq("rx_perror", 32'(Rx_PERROR), 32'(e[DATA_BITS]));
    check_eq("rx_ferror", 32'(Rx_FERROR), 32'(e[DATA_BITS+1]));
    if (do_pop) begin
      void'(exp_q.pop_front());
      Rx_RD = 1'b1;
      @(negedge clk);
      Rx_RD = 1'b0;
    end
  endtask

  task automatic tx_send(input logic [DATA_BITS-1:0] d);
    int unsigned n;
    int unsigned exp_len;
    bit          saw_low;
    n = 0;
    while (Tx_BUSY === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_ready", 32'(Tx_BUSY), 0);
    exp_len = frame_clocks(baud_select, parity_sel, stop2);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR   = 1'b0;
    n       = 0;
    saw_low = 1'b0;
    while (Tx_BUSY === 1'b1 && n < 2 * exp_len) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
      n++;
    end
    check_eq("tx_busy_len", n, exp_len);
    if (loopback) begin
      check_eq("loopback_txd_idle", 32'(saw_low), 0);
      model_push(1'b0, 1'b0, d);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rx_drive_frame(input logic [DATA_BITS-1:0] d, input bit par_bad, input bit stop_low);
    int unsigned bp;
    bp = 16 * div_of(baud_select);
    RxD = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      RxD = d[i];
      repeat (bp) @(negedge clk);
    end
    if (parity_sel != 2'b00) begin
      RxD = par_bit(d, parity_sel) ^ par_bad;
      repeat (bp) @(negedge clk);
    end
    if (stop_low) begin
      RxD = 1'b0;
      repeat (10 * bp / 16) @(negedge clk);
      RxD = 1'b1;
      repeat (bp - 10 * bp / 16) @(negedge clk);
    end else begin
      RxD = 1'b1;
      repeat (bp) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (bp) @(negedge clk);
    model_push(stop_low, par_bad && (parity_sel != 2'b00), d);
  endtask

  initial begin
    #(150_000 * 20);
    $display("FAIL watchdog: got no completion, expected end within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_BITS-1:0] d;
    bit                   saw;

    reset = 1'b0; baud_select = 3'b111; parity_sel = 2'b01; stop2 = 1'b0;
    loopback = 1'b1; Tx_EN = 1'b1; Tx_WR = 1'b0; Tx_DATA = '0;
    Rx_EN = 1'b1; RxD = 1'b1; Rx_RD = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(TxD), 1);
    check_eq("rst_tx_busy", 32'(Tx_BUSY), 0);
    check_eq("rst_rx_valid", 32'(Rx_VALID), 0);
    check_eq("rst_rx_data", 32'(Rx_DATA), 0);
    check_eq("rst_rx_perror", 32'(Rx_PERROR), 0);
    check_eq("rst_rx_ferror", 32'(Rx_FERROR), 0);
    check_eq("rst_rx_overrun", 32'(Rx_OVERRUN), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of 0xAA at 115200, even parity, one stop bit.
    tx_send(8'hAA);
    check_head(1'b1);
    check_head(1'b0);

    // Random words with random parity and stop settings through loopback.
    for (int i = 0; i < 3; i++) begin
      parity_sel = 2'($urandom_range(0, 3));
      stop2      = 1'($urandom_range(0, 1));
      d          = DATA_BITS'($urandom);
      tx_send(d);
      check_head(1'b1);
    end
    check_head(1'b0);

    // External frames: wrong parity, then a low stop bit.
    loopback = 1'b0; parity_sel = 2'b10; stop2 = 1'b1;
    repeat (10) @(negedge clk);
    rx_drive_frame(8'h89, 1'b1, 1'b0);
    check_head(1'b1);
    rx_drive_frame(DATA_BITS'($urandom), 1'b0, 1'b1);
    check_head(1'b1);
    check_head(1'b0);

    // Overrun: five words into a four-entry FIFO without reading.
    loopback = 1'b1; parity_sel = 2'b01; stop2 = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) tx_send(DATA_BITS'($urandom));
    check_eq("overrun_set", 32'(Rx_OVERRUN), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) check_head(1'b1);
    check_head(1'b0);
    check_eq("overrun_sticky", 32'(Rx_OVERRUN), 32'(exp_ovr));
    Rx_EN = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_ovr = 1'b0;
    check_eq("overrun_cleared", 32'(Rx_OVERRUN), 32'(exp_ovr));
    Rx_EN = 1'b1;
    repeat (5) @(negedge clk);

    // Transmit abort mid-data, with an ignored write while busy.
    loopback = 1'b0; parity_sel = 2'b00; stop2 = 1'b0;
    @(negedge clk);
    Tx_DATA = 8'h5A; Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("abort_start_bit", 32'(TxD), 0);
    check_eq("abort_busy_before", 32'(Tx_BUSY), 1);
    repeat (3 * 16 * div_of(baud_select)) @(negedge clk);
    Tx_DATA = 8'hFF; Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (10) @(negedge clk);
    Tx_EN = 1'b0;
    @(negedge clk);
    check_eq("abort_txd", 32'(TxD), 1);
    check_eq("abort_busy", 32'(Tx_BUSY), 0);
    Tx_EN = 1'b1;
    saw = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) saw = 1'b1;
    end
    check_eq("no_second_frame", 32'(saw), 0);

    // Glitch shorter than half a bit, then a clean frame left in the FIFO.
    parity_sel = 2'b01;
    RxD = 1'b0;
    repeat (4 * div_of(baud_select)) @(negedge clk);
    RxD = 1'b1;
    repeat (40 * div_of(baud_select)) @(negedge clk);
    check_eq("glitch_no_push", 32'(Rx_VALID), 0);
    rx_drive_frame(DATA_BITS'($urandom), 1'b0, 1'b0);
    check_head(1'b0);

    // Reset in the middle of a received frame.
    RxD = 1'b0;
    repeat (3 * 16 * div_of(baud_select) + 8 * div_of(baud_select)) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check_eq("midrst_rx_valid", 32'(Rx_VALID), 0);
    check_eq("midrst_rx_data", 32'(Rx_DATA), 0);
    check_eq("midrst_txd", 32'(TxD), 1);
    check_eq("midrst_tx_busy", 32'(Tx_BUSY), 0);
    check_eq("midrst_overrun", 32'(Rx_OVERRUN), 0);
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20 * div_of(baud_select)) @(negedge clk);
    check_eq("no_partial_push", 32'(Rx_VALID), 0);
    rx_drive_frame(DATA_BITS'($urandom), 1'b0, 1'b0);
    check_head(1'b1);
    check_head(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
